async_fifo_reader: RTL

Read-side consumer for the asynchronous FIFO, running entirely in the read clock domain. Issues r_en against the FIFO's empty flag and captures data_out after the FIFO read latency. Presents the captured words downstream as a valid/ready stream through an internal skid buffer. Supports a flush mode that drains and discards FIFO contents. Sits between the FIFO read port and any read-domain consumer.

---
 rtl/async_fifo_reader_if.sv | 29 ++
 rtl/async_fifo_reader.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/async_fifo_reader_if.sv
// async_fifo_reader_if
// Bundles the two handshakes of the FIFO read-side consumer:
//   - FIFO read port: empty, data_out (from the FIFO), r_en (to the FIFO)
//   - downstream stream: m_valid, m_data (to the consumer), m_ready (from it)
// Modports:
//   master : the reader (drives r_en, m_valid, m_data)
//   slave  : the FIFO plus the downstream consumer seen as one party
// Handshake rule for the stream: a word transfers on every r_clk edge where
// m_valid && m_ready; while m_valid && !m_ready, m_data is held stable.
interface async_fifo_reader_if #(
    parameter int WIDTH = 8
);
    logic             empty;
    logic [WIDTH-1:0] data_out;
    logic             r_en;
    logic             m_valid;
    logic [WIDTH-1:0] m_data;
    logic             m_ready;

    modport master (
        input  empty, data_out, m_ready,
        output r_en, m_valid, m_data
    );

    modport slave (
        output empty, data_out, m_ready,
        input  r_en, m_valid, m_data
    );
endinterface

// File: rtl/async_fifo_reader.sv
// async_fifo_reader
// Read-domain consumer of an asynchronous FIFO. Issues r_en against the FIFO
// empty flag, captures data_out RD_LAT cycles later into a small skid buffer
// and presents the buffered words downstream as a valid/ready stream. A flush
// mode drains the FIFO and discards everything it reads.
// Ports:
//   r_clk      read-domain clock (posedge)
//   r_rst      asynchronous active-low reset
//   en         read enable (IDLE <-> RUN)
//   flush      one-cycle pulse, enters FLUSH from IDLE or RUN
//   fifo_if    master modport: empty/data_out/r_en and m_valid/m_data/m_ready
//   busy       FLUSH state or reads still in flight
//   buf_level  skid buffer occupancy
//   dbg_state  current FSM state (0 IDLE, 1 RUN, 2 FLUSH)
// Optional: define ASF_RD_STATS_EN to add saturating counters rd_words (words
// delivered downstream) and drop_words (words discarded by flush).
module async_fifo_reader #(
    parameter int WIDTH     = 8,
    parameter int RD_LAT    = 1,
    parameter int BUF_DEPTH = 4
) (
    input  logic                        r_clk,
    input  logic                        r_rst,
    input  logic                        en,
    input  logic                        flush,
    async_fifo_reader_if.master         fifo_if,
    output logic                        busy,
    output logic [$clog2(BUF_DEPTH):0]  buf_level,
    output logic [1:0]                  dbg_state
`ifdef ASF_RD_STATS_EN
    ,
    output logic [31:0]                 rd_words,
    output logic [15:0]                 drop_words
`endif
);
    localparam int AW = $clog2(BUF_DEPTH);
    localparam int LW = AW + 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_FLUSH = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [RD_LAT-1:0] inflight_q, inflight_d;
    logic [WIDTH-1:0]  mem_q [BUF_DEPTH];
    logic [AW-1:0]     head_q, head_d, tail_q, tail_d;
    logic [LW-1:0]     level_q, level_d;
    logic [LW:0]       credit_used;
    logic              r_en_c, m_valid_c;
    logic              landing, flush_start, push, pop;

    // Outstanding reads plus buffered words must stay below BUF_DEPTH so a
    // word that lands always has a free slot, regardless of m_ready.
    always_comb begin
        credit_used = {1'b0, level_q} + (LW+1)'($countones(inflight_q));
        r_en_c = 1'b0;
        case (state_q)
            S_RUN:   r_en_c = !fifo_if.empty && (credit_used < (LW+1)'(BUF_DEPTH));
            S_FLUSH: r_en_c = !fifo_if.empty;
            default: r_en_c = 1'b0;
        endcase
    end

    // inflight[0] records this cycle's r_en; the last stage marks the cycle
    // in which data_out carries the word.
    always_comb begin
        inflight_d    = inflight_q;
        inflight_d[0] = r_en_c;
        for (int i = 1; i < RD_LAT; i++) begin
            inflight_d[i] = inflight_q[i-1];
        end
    end

    assign landing     = inflight_q[RD_LAT-1];
    assign flush_start = flush && (state_q != S_FLUSH);
    // A word landing in the flush-entry cycle goes with the cleared buffer.
    assign push        = landing && (state_q != S_FLUSH) && !flush_start;
    assign m_valid_c   = (level_q != '0);
    assign pop         = m_valid_c && fifo_if.m_ready;

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        level_d = level_q;
        if (flush_start) begin
            head_d  = '0;
            tail_d  = '0;
            level_d = '0;
        end else begin
            if (push) tail_d = tail_q + 1'b1;
            if (pop)  head_d = head_q + 1'b1;
            case ({push, pop})
                2'b10:   level_d = level_q + 1'b1;
                2'b01:   level_d = level_q - 1'b1;
                default: level_d = level_q;
            endcase
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (flush)   state_d = S_FLUSH;
                else if (en) state_d = S_RUN;
            end
            S_RUN: begin
                if (flush)    state_d = S_FLUSH;
                else if (!en) state_d = S_IDLE;
            end
            S_FLUSH: begin
                if (fifo_if.empty && (inflight_q == '0)) begin
                    state_d = en ? S_RUN : S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge r_clk or negedge r_rst) begin
        if (!r_rst) begin
            state_q    <= S_IDLE;
            inflight_q <= '0;
            head_q     <= '0;
            tail_q     <= '0;
            level_q    <= '0;
        end else begin
            state_q    <= state_d;
            inflight_q <= inflight_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
            level_q    <= level_d;
        end
    end

    // Storage needs no reset: m_data is gated by m_valid.
    always_ff @(posedge r_clk) begin
        if (push) mem_q[tail_q] <= fifo_if.data_out;
    end

    assign fifo_if.r_en    = r_en_c;
    assign fifo_if.m_valid = m_valid_c;
    assign fifo_if.m_data  = m_valid_c ? mem_q[head_q] : '0;
    assign busy            = (state_q == S_FLUSH) || (inflight_q != '0);
    assign buf_level       = level_q;
    assign dbg_state       = state_q;

`ifdef ASF_RD_STATS_EN
    logic [31:0] rd_words_q, rd_words_d;
    logic [15:0] drop_words_q, drop_words_d;
    logic [LW:0] drop_add;
    logic [16:0] drop_sum;

    // A word popped in the flush-entry cycle was delivered, not dropped.
    always_comb begin
        rd_words_d = rd_words_q;
        if (pop && (rd_words_q != '1)) rd_words_d = rd_words_q + 32'd1;
        drop_add = '0;
        if (flush_start) begin
            drop_add = {1'b0, level_q} - (LW+1)'(pop) + (LW+1)'(landing);
        end else if ((state_q == S_FLUSH) && landing) begin
            drop_add = (LW+1)'(1);
        end
        drop_sum     = {1'b0, drop_words_q} + 17'(drop_add);
        drop_words_d = drop_sum[16] ? '1 : drop_sum[15:0];
    end

    always_ff @(posedge r_clk or negedge r_rst) begin
        if (!r_rst) begin
            rd_words_q   <= '0;
            drop_words_q <= '0;
        end else begin
            rd_words_q   <= rd_words_d;
            drop_words_q <= drop_words_d;
        end
    end

    assign rd_words   = rd_words_q;
    assign drop_words = drop_words_q;
`endif
endmodule
